// File: rtl/mac_pkg.sv
// Shared definitions for the MAC operand issuer and MAC_control_unit:
// issuer FSM encoding, default operand/result widths and mode encodings.
package mac_pkg;

    // Default datapath widths shared across the MAC top level
    localparam int MAC_OP_W  = 8;
    localparam int MAC_RES_W = 17;

    // Mode encodings understood by MAC_control_unit
    localparam logic MODE_TRI  = 1'b1;  // (a*x + b)*x + c
    localparam logic MODE_SUMP = 1'b0;  // a0*x0 + a1*x1

    // Issuer FSM states
    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_SUMP_SECOND = 2'd1,
        ST_WAIT        = 2'd2
    } issuer_state_t;

endpackage

// File: rtl/mac_operand_fifo.sv
// Synchronous operand-set FIFO. Push while full is dropped even when a pop
// happens in the same cycle; pop while empty is ignored. Pointers wrap
// naturally because DEPTH is a power of two.
module mac_operand_fifo
    import mac_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 4 * MAC_OP_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full      = (count == CNT_W'(DEPTH));
    assign push_ok   = push && !full;
    assign pop_ok    = pop && (count != '0);
    assign head_data = mem[rd_ptr];

    // Storage, pointers and occupancy; reset empties the FIFO
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

endmodule

// File: rtl/mac_operand_issuer.sv
// Operand issuer for MAC_control_unit. Buffers host operand sets, issues
// trinomial (one set) or sum-of-products (two a/x pairs) jobs with the
// valid_input/last_input timing the control unit expects, and captures the
// one-cycle valid_output/final_output result as res_valid/res_data.
// Optional build macro: MAC_ISSUER_TIMEOUT_EN adds a WAIT watchdog that
// pulses err and abandons the job after TIMEOUT cycles.
//
// Handshake: valid_input/last_input are a one-cycle strobe marking the first
// operand cycle of a job; operands and mode stay stable until the job ends.
// valid_output is a one-cycle strobe accepted only in WAIT.
module mac_operand_issuer
    import mac_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int OP_W    = MAC_OP_W,
    parameter int RES_W   = MAC_RES_W,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [OP_W-1:0]  wr_a,
    input  logic [OP_W-1:0]  wr_b,
    input  logic [OP_W-1:0]  wr_c,
    input  logic [OP_W-1:0]  wr_x,
    input  logic             mode_sel,
    output logic             full,
    output logic             busy,
    output logic             valid_input,
    output logic             last_input,
    output logic [OP_W-1:0]  num_a,
    output logic [OP_W-1:0]  num_b,
    output logic [OP_W-1:0]  num_c,
    output logic [OP_W-1:0]  num_x,
    output logic             mode,
    input  logic             valid_output,
    input  logic [RES_W-1:0] final_output,
    output logic             res_valid,
    output logic [RES_W-1:0] res_data,
    output logic             err,
    output logic [1:0]       dbg_state
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int SET_W = 4 * OP_W;

    issuer_state_t    state_q, state_d;
    logic [SET_W-1:0] head_set;
    logic [OP_W-1:0]  head_a, head_b, head_c, head_x;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_pop;

    logic             valid_input_d, last_input_d;
    logic [OP_W-1:0]  num_a_d, num_b_d, num_c_d, num_x_d;
    logic             mode_d;
    logic             res_valid_d;
    logic [RES_W-1:0] res_data_d;

`ifdef MAC_ISSUER_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    logic [TMR_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             err_q, err_d;
`endif

    mac_operand_fifo #(
        .DEPTH (DEPTH),
        .W     (SET_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (wr_en),
        .push_data ({wr_a, wr_b, wr_c, wr_x}),
        .pop       (fifo_pop),
        .head_data (head_set),
        .count     (fifo_count),
        .full      (full)
    );

    assign head_a = head_set[4*OP_W-1 -: OP_W];
    assign head_b = head_set[3*OP_W-1 -: OP_W];
    assign head_c = head_set[2*OP_W-1 -: OP_W];
    assign head_x = head_set[OP_W-1   -: OP_W];

    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

    // Next-state and next-output decode; operands/mode hold unless reloaded
    always_comb begin
        state_d       = state_q;
        valid_input_d = 1'b0;
        last_input_d  = 1'b0;
        num_a_d       = num_a;
        num_b_d       = num_b;
        num_c_d       = num_c;
        num_x_d       = num_x;
        mode_d        = mode;
        res_valid_d   = 1'b0;
        res_data_d    = res_data;
        fifo_pop      = 1'b0;
`ifdef MAC_ISSUER_TIMEOUT_EN
        err_d         = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (mode_sel == MODE_TRI && fifo_count >= CNT_W'(1)) begin
                    num_a_d       = head_a;
                    num_b_d       = head_b;
                    num_c_d       = head_c;
                    num_x_d       = head_x;
                    fifo_pop      = 1'b1;
                    valid_input_d = 1'b1;
                    last_input_d  = 1'b1;
                    mode_d        = MODE_TRI;
                    state_d       = ST_WAIT;
                end else if (mode_sel == MODE_SUMP && fifo_count >= CNT_W'(2)) begin
                    num_a_d       = head_a;
                    num_x_d       = head_x;
                    fifo_pop      = 1'b1;
                    valid_input_d = 1'b1;
                    last_input_d  = 1'b1;
                    mode_d        = MODE_SUMP;
                    state_d       = ST_SUMP_SECOND;
                end
            end
            ST_SUMP_SECOND: begin
                // Second pair is guaranteed present: IDLE required two sets
                num_a_d  = head_a;
                num_x_d  = head_x;
                fifo_pop = 1'b1;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (valid_output) begin
                    res_data_d  = final_output;
                    res_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end
`ifdef MAC_ISSUER_TIMEOUT_EN
                else if (wait_cnt_q == TMR_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
`ifdef MAC_ISSUER_TIMEOUT_EN
        // Counter restarts from 0 on every WAIT entry
        if (state_q == ST_WAIT && state_d == ST_WAIT) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end else begin
            wait_cnt_d = '0;
        end
`endif
    end

    // State and registered outputs; reset drops any half-issued job
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            valid_input <= 1'b0;
            last_input  <= 1'b0;
            num_a       <= '0;
            num_b       <= '0;
            num_c       <= '0;
            num_x       <= '0;
            mode        <= 1'b0;
            res_valid   <= 1'b0;
            res_data    <= '0;
        end else begin
            state_q     <= state_d;
            valid_input <= valid_input_d;
            last_input  <= last_input_d;
            num_a       <= num_a_d;
            num_b       <= num_b_d;
            num_c       <= num_c_d;
            num_x       <= num_x_d;
            mode        <= mode_d;
            res_valid   <= res_valid_d;
            res_data    <= res_data_d;
        end
    end

`ifdef MAC_ISSUER_TIMEOUT_EN
    // WAIT watchdog counter and registered err strobe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mac_operand_issuer.sv
// Directed bench for mac_operand_issuer. A small control-unit model answers
// each job with a result computed from the operands the issuer presents;
// expected results are hand-computed constants.
module tb_mac_operand_issuer;
    import mac_pkg::*;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [7:0]  wr_a, wr_b, wr_c, wr_x;
    logic        mode_sel;
    logic        full, busy, valid_input, last_input, mode;
    logic [7:0]  num_a, num_b, num_c, num_x;
    logic        valid_output;
    logic [16:0] final_output;
    logic        res_valid;
    logic [16:0] res_data;
    logic        err;
    logic [1:0]  dbg_state;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    mac_operand_issuer #(
        .DEPTH   (4),
        .OP_W    (8),
        .RES_W   (17),
        .TIMEOUT (15)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_a         (wr_a),
        .wr_b         (wr_b),
        .wr_c         (wr_c),
        .wr_x         (wr_x),
        .mode_sel     (mode_sel),
        .full         (full),
        .busy         (busy),
        .valid_input  (valid_input),
        .last_input   (last_input),
        .num_a        (num_a),
        .num_b        (num_b),
        .num_c        (num_c),
        .num_x        (num_x),
        .mode         (mode),
        .valid_output (valid_output),
        .final_output (final_output),
        .res_valid    (res_valid),
        .res_data     (res_data),
        .err          (err),
        .dbg_state    (dbg_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; leave time 1 unit past the edge for sampling/driving
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] x);
        wr_en = 1'b1;
        wr_a = a; wr_b = b; wr_c = c; wr_x = x;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_issue(input string tag);
        for (int i = 0; i < 20 && !valid_input; i++) tick();
        check({tag, "_vi"}, 64'(valid_input), 64'd1);
    endtask

    // Control-unit model answer: one-cycle valid_output with the given value
    task automatic answer(input logic [16:0] value);
        valid_output = 1'b1;
        final_output = value;
        tick();
        valid_output = 1'b0;
        final_output = '0;
    endtask

    function automatic logic [16:0] tri_model();
        return (17'(num_a) * 17'(num_x) + 17'(num_b)) * 17'(num_x) + 17'(num_c);
    endfunction

    task automatic run_tri(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] x, input logic [16:0] exp_res);
        wait_issue(tag);
        check({tag, "_last"}, 64'(last_input), 64'd1);
        check({tag, "_ops"}, 64'({num_a, num_b, num_c, num_x}), 64'({a, b, c, x}));
        check({tag, "_mode"}, 64'(mode), 64'(MODE_TRI));
        tick();
        check({tag, "_vi_one"}, 64'({valid_input, last_input, busy}), 64'b001);
        repeat (3) tick();
        check({tag, "_held"}, 64'({num_a, num_b, num_c, num_x, mode}), 64'({a, b, c, x, MODE_TRI}));
        answer(tri_model());
        check({tag, "_res"}, 64'({res_valid, res_data, busy}), 64'({1'b1, exp_res, 1'b0}));
        tick();
        check({tag, "_res_one"}, 64'({res_valid, res_data}), 64'({1'b0, exp_res}));
    endtask

    task automatic run_sump(input string tag, input logic [7:0] a1, input logic [7:0] x1,
                            input logic [7:0] a2, input logic [7:0] x2, input logic [16:0] exp_res);
        logic [16:0] p1;
        wait_issue(tag);
        check({tag, "_first"}, 64'({last_input, num_a, num_x, mode}), 64'({1'b1, a1, x1, MODE_SUMP}));
        p1 = 17'(num_a) * 17'(num_x);
        tick();
        check({tag, "_second"}, 64'({valid_input, last_input, num_a, num_x, mode}),
              64'({1'b0, 1'b0, a2, x2, MODE_SUMP}));
        tick();
        answer(p1 + 17'(num_a) * 17'(num_x));
        check({tag, "_res"}, 64'({res_valid, res_data}), 64'({1'b1, exp_res}));
    endtask

    initial begin
        int hits;
        reset = 1'b0; wr_en = 1'b0; wr_a = '0; wr_b = '0; wr_c = '0; wr_x = '0;
        mode_sel = 1'b0; valid_output = 1'b0; final_output = '0;
        repeat (2) tick();
        check("reset_outs", 64'({valid_input, last_input, num_a, num_b, num_c, num_x, mode}), 64'd0);
        check("reset_res", 64'({res_valid, res_data, err, full, busy}), 64'd0);
        reset = 1'b1;
        tick();

        // Trinomial: (2*3+4)*3+5 = 35
        mode_sel = 1'b1;
        push(8'd2, 8'd4, 8'd5, 8'd3);
        check("tri_latency", 64'(valid_input), 64'd0);
        run_tri("tri", 8'd2, 8'd4, 8'd5, 8'd3, 17'd35);

        // Sum-of-products: 3*4 + 5*6 = 42, holds until two sets are queued
        mode_sel = 1'b0;
        push(8'd3, 8'd0, 8'd0, 8'd4);
        tick();
        check("sump_hold", 64'({valid_input, busy}), 64'd0);
        push(8'd5, 8'd0, 8'd0, 8'd6);
        run_sump("sump", 8'd3, 8'd4, 8'd5, 8'd6, 17'd42);
        tick();

        // FIFO full: park a dummy job in WAIT, then push five sets
        mode_sel = 1'b1;
        push(8'd1, 8'd1, 8'd1, 8'd1);
        wait_issue("dummy");
        tick();
        check("dummy_state", 64'(dbg_state), 64'(ST_WAIT));
        push(8'd1, 8'd2, 8'd3, 8'd4);
        push(8'd2, 8'd1, 8'd0, 8'd5);
        push(8'd3, 8'd0, 8'd7, 8'd2);
        check("not_full_3", 64'(full), 64'd0);
        push(8'd0, 8'd9, 8'd1, 8'd3);
        check("full_4", 64'(full), 64'd1);
        push(8'd7, 8'd7, 8'd7, 8'd7);
        check("full_5", 64'(full), 64'd1);
        answer(tri_model());
        check("dummy_res", 64'({res_valid, res_data}), 64'({1'b1, 17'd3}));
        // Pop and push in the same cycle while full: the push is dropped
        wr_en = 1'b1; wr_a = 8'd7; wr_b = 8'd7; wr_c = 8'd7; wr_x = 8'd7;
        tick();
        wr_en = 1'b0;
        check("pop_push_full", 64'({full, res_valid, valid_input}), 64'b001);
        run_tri("job1", 8'd1, 8'd2, 8'd3, 8'd4, 17'd27);
        run_tri("job2", 8'd2, 8'd1, 8'd0, 8'd5, 17'd55);
        run_tri("job3", 8'd3, 8'd0, 8'd7, 8'd2, 17'd19);
        run_tri("job4", 8'd0, 8'd9, 8'd1, 8'd3, 17'd28);
        hits = 0;
        repeat (6) begin
            tick();
            if (valid_input || busy) hits++;
        end
        check("drained", 64'(hits), 64'd0);

        // Mode change during WAIT has no effect until the next job
        push(8'd2, 8'd4, 8'd5, 8'd3);
        wait_issue("mchg");
        tick();
        mode_sel = 1'b0;
        push(8'd1, 8'd0, 8'd0, 8'd2);
        push(8'd3, 8'd0, 8'd0, 8'd4);
        check("mchg_mode_held", 64'({mode, busy}), 64'b11);
        answer(tri_model());
        check("mchg_res", 64'({res_valid, res_data, mode}), 64'({1'b1, 17'd35, 1'b1}));
        run_sump("mchg_next", 8'd1, 8'd2, 8'd3, 8'd4, 17'd14);
        tick();

        // Reset during WAIT clears everything immediately
        mode_sel = 1'b1;
        push(8'd1, 8'd1, 8'd1, 8'd1);
        push(8'd2, 8'd2, 8'd2, 8'd2);
        wait_issue("rst");
        tick();
        #1 reset = 1'b0;
        #1;
        check("rst_async_outs", 64'({valid_input, last_input, num_a, num_b, num_c, num_x, mode}), 64'd0);
        check("rst_async_res", 64'({res_valid, res_data, busy, full, dbg_state}), 64'd0);
        #1 reset = 1'b1;
        tick();
        answer(17'd99);
        check("rst_late_vo", 64'({res_valid, res_data}), 64'd0);
        hits = 0;
        repeat (5) begin
            tick();
            if (valid_input) hits++;
        end
        check("rst_fifo_empty", 64'(hits), 64'd0);

        // WAIT with no answer from the control unit
        push(8'd2, 8'd4, 8'd5, 8'd3);
        wait_issue("to");
`ifdef MAC_ISSUER_TIMEOUT_EN
        hits = 0;
        repeat (14) begin
            tick();
            if (err) hits++;
        end
        check("to_early", 64'({hits[7:0], busy}), 64'({8'd0, 1'b1}));
        tick();
        check("to_err", 64'({err, res_valid, busy}), 64'b100);
        tick();
        check("to_err_one", 64'({err, dbg_state}), 64'({1'b0, ST_IDLE}));
`else
        hits = 0;
        repeat (20) begin
            tick();
            if (err || !busy) hits++;
        end
        check("no_to_wait", 64'(hits), 64'd0);
        answer(tri_model());
        check("no_to_res", 64'({res_valid, res_data}), 64'({1'b1, 17'd35}));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
